// File: rtl/cacheline_burst_adaptor_if.sv
// Bus bundles for cacheline_burst_adaptor: the 256-bit line port toward the
// L2/write buffer and the narrow beat port toward main memory.
interface pmem_line_if;
    logic [31:0]  address;
    logic         read;
    logic         write;
    logic [255:0] wdata;
    logic [255:0] rdata;
    logic         resp;

    modport master (output address, read, write, wdata, input rdata, resp);
    modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

interface mem_beat_if #(parameter int BEAT_WIDTH = 64);
    logic [31:0]           address;
    logic                  read;
    logic                  write;
    logic [BEAT_WIDTH-1:0] wdata;
    logic [BEAT_WIDTH-1:0] rdata;
    logic                  resp;

    modport master (output address, read, write, wdata, input rdata, resp);
    modport slave  (input address, read, write, wdata, output rdata, resp);
endinterface

// File: rtl/cacheline_burst_adaptor.sv
// Splits each 256-bit line read/write into NUM_BEATS memory beats and pulses pmem.resp once per line.
// Optional stall watchdog + sticky mem_err: define CACHELINE_BURST_ADAPTOR_TIMEOUT_EN.
module cacheline_burst_adaptor #(
    parameter int BEAT_WIDTH = 64,
    parameter int NUM_BEATS  = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    pmem_line_if.slave pmem,
    mem_beat_if.master mem
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
    ,
    output logic       mem_err
`endif
);
    localparam int CW = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

    if (BEAT_WIDTH * NUM_BEATS != 256 || TIMEOUT < 1) begin : g_bad_cfg
        $error("cacheline_burst_adaptor: BEAT_WIDTH*NUM_BEATS must be 256 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {IDLE, RD_BURST, WR_BURST, DONE} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [31:0]    addr_q, addr_nx;
    logic [255:0]   line_buf, line_nx;
    logic           last_beat;

`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT + 1);
    logic [WDW-1:0] wd, wd_nx;
    logic           err_nx;
`endif

    assign last_beat = (cnt == CW'(NUM_BEATS - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            line_buf <= '0;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
            wd       <= '0;
            mem_err  <= 1'b0;
`endif
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            addr_q   <= addr_nx;
            line_buf <= line_nx;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
            wd       <= wd_nx;
            mem_err  <= err_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        addr_nx  = addr_q;
        line_nx  = line_buf;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
        wd_nx    = wd;
        err_nx   = mem_err;
`endif
        case (state)
            IDLE: begin
                // Writes win so evictions drain ahead of fills.
                if (pmem.write) begin
                    state_nx = WR_BURST;
                    cnt_nx   = '0;
                    addr_nx  = pmem.address & ~32'h1F;
                    line_nx  = pmem.wdata;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
                    wd_nx    = '0;
`endif
                end else if (pmem.read) begin
                    state_nx = RD_BURST;
                    cnt_nx   = '0;
                    addr_nx  = pmem.address & ~32'h1F;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
                    // Beats lost to a timeout must read back as zero.
                    line_nx  = '0;
                    wd_nx    = '0;
`endif
                end
            end
            RD_BURST, WR_BURST: begin
                if (mem.resp) begin
                    if (state == RD_BURST)
                        line_nx[cnt*BEAT_WIDTH +: BEAT_WIDTH] = mem.rdata;
                    cnt_nx = last_beat ? '0 : cnt + 1'b1;
                    if (last_beat)
                        state_nx = DONE;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
                    wd_nx = '0;
                end else if (wd == WDW'(TIMEOUT - 1)) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                    err_nx   = 1'b1;
                end else begin
                    wd_nx = wd + 1'b1;
`endif
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign pmem.rdata  = line_buf;
    assign pmem.resp   = (state == DONE);
    assign mem.address = addr_q;
    assign mem.read    = (state == RD_BURST);
    assign mem.write   = (state == WR_BURST);
    assign mem.wdata   = line_buf[cnt*BEAT_WIDTH +: BEAT_WIDTH];
endmodule

// File: tb/tb_cacheline_burst_adaptor.sv
// Bench for cacheline_burst_adaptor: directed and random line transactions against a
// line-granular memory model; covers the watchdog when CACHELINE_BURST_ADAPTOR_TIMEOUT_EN is set.
module tb_cacheline_burst_adaptor;
    localparam int BW = 64;
    localparam int NB = 4;
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
    localparam int TO = 8;
    logic mem_err;
`else
    localparam int TO = 255;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pmem_line_if pmem_bus ();
    mem_beat_if #(.BEAT_WIDTH(BW)) mem_bus ();

    cacheline_burst_adaptor #(.BEAT_WIDTH(BW), .NUM_BEATS(NB), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .pmem  (pmem_bus.slave),
        .mem   (mem_bus.master)
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
        ,
        .mem_err (mem_err)
`endif
    );

    int n_chk = 0;
    int n_fail = 0;

    // Memory model: whole lines keyed by aligned address; unwritten lines get a known pattern.
    logic [255:0] mem_line [logic [31:0]];
    int           resp_mode;   // 0 every cycle, 1 every 3rd, 2 random, 3 first beat only
    int           rd_beats = 0;
    int           pulses = 0;

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] r;
        if (mem_line.exists(a)) return mem_line[a];
        for (int b = 0; b < NB; b++) r[b*BW +: BW] = {a, 24'hC0FFEE, 8'(b)};
        return r;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory responder: drives resp/rdata on negedges, books accepted beats.
    initial begin
        int           bi = 0, act = 0;
        bit           was_wr = 0, r;
        logic [31:0]  baddr = '0;
        logic [255:0] acc = '0, ln;
        logic [BW-1:0] last_wd = '0;
        mem_bus.resp  = 1'b0;
        mem_bus.rdata = '0;
        forever begin
            @(negedge clk);
            if (pmem_bus.resp === 1'b1) pulses++;
            if (reset) begin
                mem_bus.resp = 1'b0; bi = 0; act = 0;
            end else begin
                if (mem_bus.resp) begin
                    if (was_wr) acc[bi*BW +: BW] = last_wd;
                    else rd_beats++;
                    bi++;
                    if (bi == NB) begin
                        if (was_wr) mem_line[baddr] = acc;
                        bi = 0;
                    end
                end
                if (mem_bus.read || mem_bus.write) begin
                    was_wr = mem_bus.write;
                    baddr  = mem_bus.address;
                    act++;
                    case (resp_mode)
                        0:       r = 1'b1;
                        1:       r = (act % 3 == 0);
                        2:       r = 1'($urandom_range(0, 1));
                        default: r = (act == 1);
                    endcase
                    ln = line_of(baddr);
                    mem_bus.resp  = r;
                    mem_bus.rdata = ln[bi*BW +: BW];
                    last_wd = mem_bus.wdata;
                end else begin
                    mem_bus.resp = 1'b0; bi = 0; act = 0;
                end
            end
        end
    end

    // Waits for pmem.resp; returns latency, burst-cycle counts, burst address and idle gap.
    task automatic wait_resp(input string tag, output int lat, output int nrd, output int nwr,
                             output logic [31:0] baddr, output int gap);
        bit seen = 0;
        lat = 0; nrd = 0; nwr = 0; baddr = '0; gap = 0;
        while (1) begin
            @(negedge clk); #1;
            lat++;
            if (pmem_bus.resp === 1'b1) break;
            if (lat > 400) begin
                n_chk++; n_fail++;
                $error("FAIL %s_timeout: no pmem_resp within 400 cycles", tag);
                break;
            end
            check({tag, "_excl"}, 256'(mem_bus.read & mem_bus.write), 256'(0));
            if (mem_bus.read)  nrd++;
            if (mem_bus.write) nwr++;
            if (!seen && (mem_bus.read || mem_bus.write)) begin
                seen = 1; baddr = mem_bus.address; gap = lat - 1;
            end
        end
    endtask

    task automatic post_done(input string tag);
        @(negedge clk); #1;
        check({tag, "_resp_1cyc"}, 256'(pmem_bus.resp), 256'(0));
    endtask

    initial begin
        int lat, nrd, nwr, gap, p0, b0;
        logic [31:0]  ba, a;
        logic [255:0] wd, exp_l;
        bit           is_wr;

        resp_mode = 0;
        pmem_bus.address = '0; pmem_bus.read = 1'b0; pmem_bus.write = 1'b0; pmem_bus.wdata = '0;
        reset = 1'b0;
        #2 reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_resp",  256'(pmem_bus.resp), 256'(0));
        check("rst_rdata", pmem_bus.rdata, 256'(0));
        check("rst_mrd",   256'(mem_bus.read), 256'(0));
        check("rst_mwr",   256'(mem_bus.write), 256'(0));
        check("rst_maddr", 256'(mem_bus.address), 256'(0));
        check("rst_mwdat", 256'(mem_bus.wdata), 256'(0));
`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
        check("rst_err",   256'(mem_err), 256'(0));
`endif
        reset = 1'b0;

        // Read with zero wait states
        mem_line[32'h0000_1220] = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        pmem_bus.address = 32'h0000_1234; pmem_bus.read = 1'b1;
        wait_resp("rd0", lat, nrd, nwr, ba, gap);
        check("rd0_lat",   256'(lat), 256'(1 + NB));
        check("rd0_nrd",   256'(nrd), 256'(NB));
        check("rd0_addr",  256'(ba), 256'(32'h0000_1220));
        check("rd0_rdata", pmem_bus.rdata, {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}});
        pmem_bus.read = 1'b0;
        post_done("rd0");

        // Write with a response every third cycle
        resp_mode = 1;
        wd = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        pmem_bus.address = 32'h8000_0040; pmem_bus.write = 1'b1; pmem_bus.wdata = wd;
        wait_resp("wr0", lat, nrd, nwr, ba, gap);
        check("wr0_lat",  256'(lat), 256'(1 + 3 * NB));
        check("wr0_nwr",  256'(nwr), 256'(3 * NB));
        check("wr0_addr", 256'(ba), 256'(32'h8000_0040));
        check("wr0_line", line_of(32'h8000_0040), wd);
        pmem_bus.write = 1'b0;
        post_done("wr0");

        // Simultaneous request: write first, read accepted after one IDLE cycle
        resp_mode = 2;
        wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        pmem_bus.address = 32'h0000_4000; pmem_bus.wdata = wd;
        pmem_bus.write = 1'b1; pmem_bus.read = 1'b1;
        wait_resp("sim_w", lat, nrd, nwr, ba, gap);
        check("sim_w_nrd",  256'(nrd), 256'(0));
        check("sim_w_line", line_of(32'h0000_4000), wd);
        pmem_bus.write = 1'b0; pmem_bus.address = 32'h0000_5008;
        wait_resp("sim_r", lat, nrd, nwr, ba, gap);
        check("sim_r_gap",   256'(gap), 256'(1));
        check("sim_r_addr",  256'(ba), 256'(32'h0000_5000));
        check("sim_r_rdata", pmem_bus.rdata, line_of(32'h0000_5000));
        pmem_bus.read = 1'b0;
        post_done("sim_r");

        // Reset in the middle of a read burst
        resp_mode = 0;
        b0 = rd_beats; p0 = pulses;
        pmem_bus.address = 32'h0000_0300; pmem_bus.read = 1'b1;
        for (int i = 0; i < 20 && rd_beats - b0 < 2; i++) begin
            @(negedge clk); #1;
        end
        reset = 1'b1; #1;
        check("mrst_mrd",   256'(mem_bus.read), 256'(0));
        check("mrst_resp",  256'(pmem_bus.resp), 256'(0));
        check("mrst_rdata", pmem_bus.rdata, 256'(0));
        pmem_bus.read = 1'b0;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("mrst_nopulse", 256'(pulses - p0), 256'(0));
        pmem_bus.address = 32'h0000_0300; pmem_bus.read = 1'b1;
        wait_resp("mrst_rd", lat, nrd, nwr, ba, gap);
        check("mrst_rd_lat",   256'(lat), 256'(1 + NB));
        check("mrst_rd_rdata", pmem_bus.rdata, line_of(32'h0000_0300));
        pmem_bus.read = 1'b0;
        post_done("mrst_rd");

        // Back-to-back reads
        p0 = pulses;
        pmem_bus.address = 32'h0000_0100; pmem_bus.read = 1'b1;
        wait_resp("b2b0", lat, nrd, nwr, ba, gap);
        check("b2b0_rdata", pmem_bus.rdata, line_of(32'h0000_0100));
        pmem_bus.address = 32'h0000_0200;
        pmem_bus.read = 1'b0;
        @(negedge clk); #1;
        pmem_bus.read = 1'b1;
        wait_resp("b2b1", lat, nrd, nwr, ba, gap);
        check("b2b1_rdata", pmem_bus.rdata, line_of(32'h0000_0200));
        pmem_bus.read = 1'b0;
        post_done("b2b1");
        check("b2b_pulses", 256'(pulses - p0), 256'(2));

        // Random traffic over a small address window with random wait states
        resp_mode = 2;
        for (int t = 0; t < 24; t++) begin
            a = 32'h0001_0000 + 32'($urandom_range(0, 3)) * 32 + 32'($urandom_range(0, 31));
            is_wr = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp_l = is_wr ? wd : line_of(a & ~32'h1F);
            pmem_bus.address = a; pmem_bus.wdata = wd;
            pmem_bus.write = is_wr; pmem_bus.read = !is_wr;
            wait_resp("rnd", lat, nrd, nwr, ba, gap);
            check("rnd_addr", 256'(ba), 256'(a & ~32'h1F));
            if (is_wr) check("rnd_wline", line_of(a & ~32'h1F), exp_l);
            else       check("rnd_rdata", pmem_bus.rdata, exp_l);
            pmem_bus.write = 1'b0; pmem_bus.read = 1'b0;
            post_done("rnd");
        end

`ifdef CACHELINE_BURST_ADAPTOR_TIMEOUT_EN
        // Memory stalls after beat 0: watchdog ends the burst
        resp_mode = 3;
        exp_l = line_of(32'h0000_0600);
        pmem_bus.address = 32'h0000_0600; pmem_bus.read = 1'b1;
        wait_resp("to", lat, nrd, nwr, ba, gap);
        check("to_lat",   256'(lat), 256'(2 + TO));
        check("to_rdata", pmem_bus.rdata, {192'b0, exp_l[BW-1:0]});
        check("to_err",   256'(mem_err), 256'(1));
        pmem_bus.read = 1'b0;
        post_done("to");
        resp_mode = 0;
        pmem_bus.address = 32'h0000_0700; pmem_bus.read = 1'b1;
        wait_resp("to2", lat, nrd, nwr, ba, gap);
        check("to2_rdata", pmem_bus.rdata, line_of(32'h0000_0700));
        check("to2_err",   256'(mem_err), 256'(1));
        pmem_bus.read = 1'b0;
        post_done("to2");
        reset = 1'b1; #1;
        check("to_err_clr", 256'(mem_err), 256'(0));
        @(negedge clk); #1;
        reset = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "bench watchdog expired");
    end
endmodule
